// File: rtl/fir_shift_mac_ctrl.sv
`default_nettype none
// ============================================================================
// fir_shift_mac_ctrl : shift-and-add MAC sequencer driving a 0..3 bit shifter
// Revision: 1.0
// ============================================================================
module fir_shift_mac_ctrl #(
  parameter int NUM_TAPS = 8,
  parameter int ADDR_W   = 3,
  parameter int ACC_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              tap_rd_en,
  output logic [ADDR_W-1:0] tap_addr,
  input  logic [11:0]       tap_sample,
  input  logic [3:0]        tap_coef,
  output logic [1:0]        shift_count,
  output logic              shift_vld,
  output logic [11:0]       shift_data_in,
  input  logic [11:0]       shift_data_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_TAPS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_bit;
  logic [11:0]       r_sample;
  logic [3:0]        r_coef;
  logic [ACC_W-1:0]  r_acc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  w_next = S_LATCH;
      S_LATCH: w_next = S_SHIFT;
      S_SHIFT: if (r_bit == 2'd3) w_next = (r_k == LAST_K) ? S_DONE : S_READ;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: tap/bit counters, latched operands and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_addr   <= '0;
      r_bit    <= '0;
      r_sample <= '0;
      r_coef   <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        S_READ: r_addr <= r_k;
        S_LATCH: begin
          r_sample <= tap_sample;
          r_coef   <= tap_coef;
          r_bit    <= '0;
        end
        S_SHIFT: begin
          if (r_coef[r_bit]) r_acc <= r_acc + ACC_W'(shift_data_out);
          if (r_bit != 2'd3)     r_bit <= r_bit + 2'd1;
          else if (r_k != LAST_K) r_k  <= r_k + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = (r_state != S_IDLE);
    tap_rd_en     = (r_state == S_READ);
    tap_addr      = (r_state == S_READ) ? r_k : r_addr;
    shift_count   = 2'd0;
    shift_vld     = 1'b0;
    shift_data_in = 12'd0;
    out_valid     = (r_state == S_DONE);
    if (r_state == S_SHIFT) begin
      shift_count   = r_bit;
      shift_vld     = r_coef[r_bit];
      shift_data_in = r_sample;
    end
  end

  assign acc_out = r_acc;

endmodule
`default_nettype wire
